// File: rtl/dmem_arbiter_if.sv
// Shared data-RAM bus bundle: both data masters, the arbiter and the single-port RAM.
interface dmem_arbiter_if #(
  parameter int bus_addr_data_width = 8
);
  logic                           m0_req;
  logic                           m0_we;
  logic [bus_addr_data_width-1:0] m0_addr;
  logic [7:0]                     m0_wdata;
  logic                           m0_gnt;
  logic [7:0]                     m0_rdata;
  logic                           m0_rvalid;

  logic                           m1_req;
  logic                           m1_we;
  logic [bus_addr_data_width-1:0] m1_addr;
  logic [7:0]                     m1_wdata;
  logic                           m1_gnt;
  logic [7:0]                     m1_rdata;
  logic                           m1_rvalid;

  logic                           dmem_re;
  logic                           dmem_we;
  logic [bus_addr_data_width-1:0] dmem_a;
  logic [7:0]                     dmem_w;
  logic [7:0]                     dmem_r;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rdata, m0_rvalid,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rdata, m1_rvalid,
    output dmem_re, dmem_we, dmem_a, dmem_w,
    input  dmem_r
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rdata, m0_rvalid,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rdata, m1_rvalid,
    input  dmem_re, dmem_we, dmem_a, dmem_w,
    output dmem_r
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data RAM: one access per clock,
// round-robin tie-break, bounded bursts so neither master starves.
module dmem_arbiter #(
  parameter int bus_addr_data_width = 8,
  parameter int MAX_BURST           = 4
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);
  localparam int            CW      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t                         state, state_nx;
  logic [CW-1:0]                  cnt, cnt_nx;
  logic                           last, last_nx;
  logic                           gnt0, gnt1;
  logic [bus_addr_data_width-1:0] addr_sel;
  logic                           rv0_q, rv1_q;
  logic [7:0]                     rd0_q, rd1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
      rd0_q <= '0;
      rd1_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      last  <= last_nx;
      rv0_q <= gnt0 && !bus.m0_we;
      rv1_q <= gnt1 && !bus.m1_we;
      if (gnt0 && !bus.m0_we) rd0_q <= bus.dmem_r;
      if (gnt1 && !bus.m1_we) rd1_q <= bus.dmem_r;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    last_nx  = last;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.m0_req && (!bus.m1_req || last)) gnt0 = 1'b1;
        else if (bus.m1_req)                      gnt1 = 1'b1;
      end
      OWN0: begin
        if (bus.m0_req && !(bus.m1_req && cnt == CNT_MAX)) gnt0 = 1'b1;
        else if (bus.m1_req)                                gnt1 = 1'b1;
      end
      OWN1: begin
        if (bus.m1_req && !(bus.m0_req && cnt == CNT_MAX)) gnt1 = 1'b1;
        else if (bus.m0_req)                                gnt0 = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end

    if (gnt0) begin
      state_nx = OWN0;
      last_nx  = 1'b0;
      cnt_nx   = (state != OWN0) ? '0 : (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    end else if (gnt1) begin
      state_nx = OWN1;
      last_nx  = 1'b1;
      cnt_nx   = (state != OWN1) ? '0 : (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    end else begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end
  end

  always_comb begin
    addr_sel     = '0;
    bus.dmem_re  = 1'b0;
    bus.dmem_we  = 1'b0;
    bus.dmem_w   = '0;
    if (gnt0) begin
      addr_sel    = bus.m0_addr;
      bus.dmem_w  = bus.m0_wdata;
      bus.dmem_we = bus.m0_we;
      bus.dmem_re = !bus.m0_we;
    end else if (gnt1) begin
      addr_sel    = bus.m1_addr;
      bus.dmem_w  = bus.m1_wdata;
      bus.dmem_we = bus.m1_we;
      bus.dmem_re = !bus.m1_we;
    end
    bus.dmem_a = addr_sel;
  end

  assign bus.m0_gnt   = gnt0;
  assign bus.m1_gnt   = gnt1;
  assign bus.m0_rdata = rd0_q;
  assign bus.m1_rdata = rd1_q;
  // A read registered just before reset is asserted must not surface during reset.
  assign bus.m0_rvalid = rv0_q && !rst;
  assign bus.m1_rvalid = rv1_q && !rst;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a grant-rule reference model queues per-cycle
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_dmem_arbiter;
  localparam int AW = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.bus_addr_data_width(AW)) bus ();
  dmem_arbiter_if #(.bus_addr_data_width(AW)) bus1 ();

  dmem_arbiter #(.bus_addr_data_width(AW), .MAX_BURST(MB)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  dmem_arbiter #(.bus_addr_data_width(AW), .MAX_BURST(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  function automatic logic [7:0] init_val(input int i);
    return (i == 16) ? 8'hA5 : 8'(i * 13 + 7);
  endfunction

  // RAM behind the MAX_BURST=4 instance
  logic [7:0] ram [256];
  logic       ram_loaded = 1'b0;
  assign bus.dmem_r = ram[bus.dmem_a];
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
      ram_loaded <= 1'b1;
    end else if (bus.dmem_we) begin
      ram[bus.dmem_a] <= bus.dmem_w;
    end
  end

  // MAX_BURST=1 instance sees permanent contention
  assign bus1.m0_req   = 1'b1;
  assign bus1.m0_we    = 1'b0;
  assign bus1.m0_addr  = 8'h01;
  assign bus1.m0_wdata = 8'h00;
  assign bus1.m1_req   = 1'b1;
  assign bus1.m1_we    = 1'b0;
  assign bus1.m1_addr  = 8'h02;
  assign bus1.m1_wdata = 8'h00;
  assign bus1.dmem_r   = 8'h77;

  typedef struct packed {
    logic       g0, g1, re, we;
    logic [7:0] a, w;
    logic       rv0, rv1;
    logic [7:0] rd0, rd1;
  } exp_t;

  exp_t       exp_q[$];
  int         hist[$];
  logic [8:0] rd0_hist[$];
  logic       rv1_hist[$];
  int         checks = 0;
  int         errors = 0;

  // pending requests per master, held until the model grants them
  logic       q[2], qwe[2];
  logic [7:0] qa[2], qw[2];
  bit         persist[2];

  // reference model state
  logic [7:0] ref_mem[256];
  int         owner, run, last;
  logic       mrv[2];
  logic [7:0] mrd[2];

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic new_req(input int k, input bit allow_write);
    q[k]   = 1'b1;
    qwe[k] = allow_write ? 1'($urandom % 2) : 1'b0;
    qa[k]  = 8'($urandom);
    qw[k]  = 8'($urandom);
  endtask

  task automatic step(input logic r);
    exp_t e;
    int   g;
    int   k;
    int   o;
    @(posedge clk);
    #1;
    rst          = r;
    bus.m0_req   = q[0];
    bus.m0_we    = qwe[0];
    bus.m0_addr  = qa[0];
    bus.m0_wdata = qw[0];
    bus.m1_req   = q[1];
    bus.m1_we    = qwe[1];
    bus.m1_addr  = qa[1];
    bus.m1_wdata = qw[1];

    g = -1;
    if (!r) begin
      if (owner < 0) begin
        if (q[0] && q[1]) g = 1 - last;
        else if (q[0])    g = 0;
        else if (q[1])    g = 1;
      end else begin
        k = owner;
        o = 1 - owner;
        if (q[k] && (!q[o] || run < MB)) g = k;
        else if (q[o])                   g = o;
      end
    end

    e     = '0;
    e.g0  = (g == 0);
    e.g1  = (g == 1);
    if (g >= 0) begin
      e.re = !qwe[g];
      e.we = qwe[g];
      e.a  = qa[g];
      e.w  = qw[g];
    end
    e.rv0 = mrv[0] && !r;
    e.rv1 = mrv[1] && !r;
    e.rd0 = mrd[0];
    e.rd1 = mrd[1];
    exp_q.push_back(e);

    if (r) begin
      owner  = -1;
      run    = 0;
      last   = 1;
      mrv[0] = 1'b0;
      mrv[1] = 1'b0;
      mrd[0] = 8'h00;
      mrd[1] = 8'h00;
    end else begin
      mrv[0] = (g == 0) && !qwe[0];
      mrv[1] = (g == 1) && !qwe[1];
      if (mrv[0]) mrd[0] = ref_mem[qa[0]];
      if (mrv[1]) mrd[1] = ref_mem[qa[1]];
      if (g < 0) begin
        owner = -1;
        run   = 0;
      end else begin
        if (qwe[g]) ref_mem[qa[g]] = qw[g];
        run   = (g == owner) ? run + 1 : 1;
        owner = g;
        last  = g;
        q[g]  = 1'b0;
        if (persist[g]) new_req(g, 1'b0);
      end
    end
  endtask

  task automatic flush();
    @(negedge clk);
    #1;
    hist.delete();
    rd0_hist.delete();
    rv1_hist.delete();
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // monitor: scoreboard pops plus the MAX_BURST=1 alternation check
  initial begin
    exp_t e;
    int   turn1;
    turn1 = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("m0_gnt",    9'(bus.m0_gnt),    9'(e.g0));
        check("m1_gnt",    9'(bus.m1_gnt),    9'(e.g1));
        check("dmem_re",   9'(bus.dmem_re),   9'(e.re));
        check("dmem_we",   9'(bus.dmem_we),   9'(e.we));
        check("dmem_a",    9'(bus.dmem_a),    9'(e.a));
        check("dmem_w",    9'(bus.dmem_w),    9'(e.w));
        check("m0_rvalid", 9'(bus.m0_rvalid), 9'(e.rv0));
        check("m1_rvalid", 9'(bus.m1_rvalid), 9'(e.rv1));
        check("m0_rdata",  9'(bus.m0_rdata),  9'(e.rd0));
        check("m1_rdata",  9'(bus.m1_rdata),  9'(e.rd1));
        hist.push_back(bus.m0_gnt ? 0 : (bus.m1_gnt ? 1 : 2));
        rd0_hist.push_back({bus.m0_rvalid, bus.m0_rdata});
        rv1_hist.push_back(bus.m1_rvalid);
      end
      check("gnt_exclusive", 9'(bus.m0_gnt & bus.m1_gnt), 9'd0);
      check("b1_gnt_exclusive", 9'(bus1.m0_gnt & bus1.m1_gnt), 9'd0);
      if (rst) begin
        check("b1_m0_gnt_rst", 9'(bus1.m0_gnt), 9'd0);
        check("b1_m1_gnt_rst", 9'(bus1.m1_gnt), 9'd0);
        turn1 = 0;
      end else begin
        check("b1_m0_gnt", 9'(bus1.m0_gnt), 9'(turn1 == 0));
        check("b1_m1_gnt", 9'(bus1.m1_gnt), 9'(turn1 == 1));
        turn1 = 1 - turn1;
      end
    end
  end

  initial begin
    int exp_seq[10];
    int first_m1;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    for (int k = 0; k < 2; k++) begin
      q[k] = 1'b0; qwe[k] = 1'b0; qa[k] = '0; qw[k] = '0;
      persist[k] = 1'b0; mrv[k] = 1'b0; mrd[k] = 8'h00;
    end
    owner = -1; run = 0; last = 1;
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
    rst = 1'b1;
    @(posedge clk);

    // reset held two cycles with both requests high
    new_req(0, 1'b0);
    new_req(1, 1'b0);
    step(1'b1);
    step(1'b1);
    flush();

    // single m0 read of the preloaded location
    q[1] = 1'b0;
    q[0] = 1'b1; qwe[0] = 1'b0; qa[0] = 8'h10; qw[0] = 8'h00;
    step(1'b0);
    step(1'b0);
    settle();
    check("t2_grant", 9'(hist[0]), 9'd0);
    check("t2_rdata", rd0_hist[1], 9'h1A5);
    check("t2_m1_rvalid", 9'(rv1_hist[1]), 9'd0);

    // continuous contention from reset
    step(1'b1);
    flush();
    persist[0] = 1'b1;
    persist[1] = 1'b1;
    new_req(0, 1'b0);
    new_req(1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0);
    settle();
    exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    for (int i = 0; i < 10; i++) check($sformatf("t3_seq%0d", i), 9'(hist[i]), 9'(exp_seq[i]));

    // m1 write lands inside an m0 burst, then m0 reads it back
    step(1'b1);
    flush();
    persist[1] = 1'b0;
    q[1] = 1'b0;
    new_req(0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0);
    q[1] = 1'b1; qwe[1] = 1'b1; qa[1] = 8'h20; qw[1] = 8'h3C;
    for (int i = 0; i < 5; i++) step(1'b0);
    settle();
    first_m1 = -1;
    for (int i = 7; i >= 0; i--) if (hist[i] == 1) first_m1 = i;
    check("t5_m1_grant_slot", 9'(first_m1), 9'd4);
    persist[0] = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0);
    q[0] = 1'b1; qwe[0] = 1'b0; qa[0] = 8'h20;
    flush();
    step(1'b0);
    step(1'b0);
    settle();
    check("t5_readback", rd0_hist[1], 9'h13C);
    check("t5_m1_rvalid", 9'(rv1_hist[1]), 9'd0);

    // reset right after a granted m1 read
    q[0] = 1'b0;
    q[1] = 1'b1; qwe[1] = 1'b0; qa[1] = 8'h33;
    flush();
    step(1'b0);
    new_req(0, 1'b0);
    new_req(1, 1'b0);
    step(1'b1);
    step(1'b1);
    step(1'b0);
    settle();
    check("t6_grant_m1", 9'(hist[0]), 9'd1);
    check("t6_rvalid_suppressed", 9'(rv1_hist[1]), 9'd0);
    check("t6_first_tie", 9'(hist[3]), 9'd0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 2; k++) if (!q[k] && ($urandom % 3 == 0)) new_req(k, 1'b1);
      step(($urandom % 250) == 0);
    end
    settle();
    check("scoreboard_drained", 9'(exp_q.size()), 9'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
